npc_reg: RTL and testbench

NPC_REG -- requirements
Module: npc_reg

---
 rtl/npc_reg.sv | 138 +++++++++++++
 tb/tb_npc_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/npc_reg.sv
// npc_reg -- next-PC register with optional single-level interrupt support.
//
// Selects the next PC from pc4/bpc/ra/jpc, forces word alignment and
// registers it. With the NPC_INTR_EN macro defined, a two-state RUN/HANDLER
// machine adds interrupt entry (save resume PC in epc, jump to EXC_VECTOR,
// one-cycle inta pulse) and eret return. Without the macro, intr and eret are
// ignored and epc/ie/inta are tied to zero; the port list is identical.
module npc_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    input  logic [1:0]  pcsource,
    input  logic        stall,
    input  logic        intr,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        ie,
    output logic        inta
);

    logic [31:0] nsel;
    logic [31:0] nsel_aligned;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next-PC source mux; purely combinational, only ever feeds registers.
    always_comb begin
        nsel = pc4;
        case (pcsource)
            2'b00:   nsel = pc4;
            2'b01:   nsel = bpc;
            2'b10:   nsel = ra;
            default: nsel = jpc;
        endcase
    end

    // Instructions are word aligned, so the low two bits are always dropped.
    assign nsel_aligned = {nsel[31:2], 2'b00};

`ifdef NPC_INTR_EN
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_HANDLER = 1'b1;

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [31:0] epc_q;
    logic [31:0] epc_d;
    logic        ie_q;
    logic        ie_d;
    logic        inta_q;
    logic        inta_d;
    logic        unused_bits;

    assign unused_bits = ^nsel[1:0];

    // Per-edge decision: stall beats interrupt entry, which beats eret,
    // which beats the ordinary sequential/branch/jump update.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        ie_d    = ie_q;
        pc_d    = pc_q;
        inta_d  = 1'b0;
        if (!stall) begin
            if (state_q == ST_RUN && intr && ie_q) begin
                epc_d   = nsel_aligned;
                pc_d    = EXC_VECTOR;
                ie_d    = 1'b0;
                state_d = ST_HANDLER;
                inta_d  = 1'b1;
            end else if (state_q == ST_HANDLER && eret) begin
                pc_d    = epc_q;
                ie_d    = 1'b1;
                state_d = ST_RUN;
            end else begin
                pc_d    = nsel_aligned;
            end
        end
    end

    // State registers; reset abandons any handler or stall in progress.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0000_0000;
            ie_q    <= 1'b1;
            inta_q  <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ie_q    <= ie_d;
            inta_q  <= inta_d;
            state_q <= state_d;
        end
    end

    assign epc  = epc_q;
    assign ie   = ie_q;
    assign inta = inta_q;
`else
    logic unused_bits;

    // Interrupt inputs have no effect in this build.
    assign unused_bits = ^{intr, eret, nsel[1:0]};

    // Plain PC update: hold on stall, otherwise take the aligned selection.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = nsel_aligned;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign epc  = 32'h0000_0000;
    assign ie   = 1'b0;
    assign inta = 1'b0;
`endif

    assign pc = pc_q;

endmodule

// File: tb/tb_npc_reg.sv
// tb_npc_reg -- self-checking bench for npc_reg (default parameters).
// Follows the NPC_INTR_EN macro: the reference model and the interrupt
// scenarios are selected to match the build under test.
module tb_npc_reg;

`ifdef NPC_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;

    logic        clk;
    logic        clrn;
    logic [31:0] pc4, bpc, ra, jpc;
    logic [1:0]  pcsource;
    logic        stall, intr, eret;
    logic [31:0] pc, epc;
    logic        ie, inta;

    int n_total;
    int n_bad;

    // Reference model state (architectural view).
    logic [31:0] m_pc, m_epc;
    logic        m_ie, m_inta, m_in_handler;

    npc_reg #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk(clk), .clrn(clrn), .pc4(pc4), .bpc(bpc), .ra(ra), .jpc(jpc),
        .pcsource(pcsource), .stall(stall), .intr(intr), .eret(eret),
        .pc(pc), .epc(epc), .ie(ie), .inta(inta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},   pc,   m_pc);
        chk({tag, ".epc"},  epc,  m_epc);
        chk({tag, ".ie"},   {31'd0, ie},   {31'd0, m_ie});
        chk({tag, ".inta"}, {31'd0, inta}, {31'd0, m_inta});
    endtask

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_epc        = 32'd0;
        m_ie         = INTR_EN;
        m_inta       = 1'b0;
        m_in_handler = 1'b0;
    endtask

    // One clock edge of the specified behaviour, then check after the edge.
    task automatic tick(input string tag);
        logic [31:0] targets [4];
        logic [31:0] next_pc;
        targets[0] = pc4;
        targets[1] = bpc;
        targets[2] = ra;
        targets[3] = jpc;
        next_pc = targets[pcsource] & 32'hFFFF_FFFC;
        m_inta = 1'b0;
        if (!stall) begin
            if (INTR_EN && !m_in_handler && intr && m_ie) begin
                m_epc = next_pc;
                m_pc = EXC_VECTOR;
                m_ie = 1'b0;
                m_in_handler = 1'b1;
                m_inta = 1'b1;
            end else if (INTR_EN && m_in_handler && eret) begin
                m_pc = m_epc;
                m_ie = 1'b1;
                m_in_handler = 1'b0;
            end else begin
                m_pc = next_pc;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
        $display("txn %s: src=%0d stall=%0b intr=%0b eret=%0b pc=%h epc=%h ie=%0b inta=%0b",
                 tag, pcsource, stall, intr, eret, pc, epc, ie, inta);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        clrn = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #2;
        clrn = 1'b1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] p4, input logic [31:0] b,
                         input logic [31:0] r, input logic [31:0] j,
                         input logic st, input logic in, input logic er);
        pcsource = src; pc4 = p4; bpc = b; ra = r; jpc = j;
        stall = st; intr = in; eret = er;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        clrn    = 1'b0;
        drive(2'b00, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2;
        clrn = 1'b1;

        // Sequential fetch from reset: 4, 8, C.
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, m_pc + 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            tick("seq");
        end

        // Branch with alignment, then branch under stall.
        drive(2'b11, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 1'b0);
        tick("jmp40");
        drive(2'b01, 32'h44, 32'h103, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick("br100");
        drive(2'b11, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 1'b0);
        tick("jmp40b");
        drive(2'b01, 32'h44, 32'h103, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        tick("br_stall");
        drive(2'b10, 32'd0, 32'd0, 32'h1237, 32'd0, 1'b0, 1'b0, 1'b0);
        tick("jr");

        // Wrap: pc4 of FFFF_FFFC arrives as 0.
        drive(2'b11, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        tick("top");
        drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick("wrap");

`ifdef NPC_INTR_EN
        drive(2'b11, 32'd0, 32'd0, 32'd0, 32'h20, 1'b0, 1'b0, 1'b0);
        tick("jmp20");
        drive(2'b00, 32'h24, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick("intr_acc");
        drive(2'b00, 32'h0C, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick("intr_held");
        for (int i = 0; i < 2; i++) begin
            drive(2'b00, m_pc + 32'd4, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
            tick("eret_stall");
        end
        drive(2'b00, m_pc + 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick("eret");
        drive(2'b00, 32'h28, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick("eret_run");
        drive(2'b00, 32'h30, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        tick("intr_eret");
        async_reset("rst_handler");
        drive(2'b00, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick("after_rst");
`else
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, m_pc + 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
            tick("noint");
        end
        async_reset("rst_mid");
        drive(2'b00, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        tick("after_rst");
`endif

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(0, 3)), m_pc + 32'd4, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0));
            tick("rand");
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
